da_gain_pipe: RTL and testbench
===============================

Name: da_gain_pipe

Overview:
- Pipelined amplitude-scaling stage between the sine sample generator and the DAC pins.
- Consumes signed sine samples, a user gain code (10..20 ≙ 1.0..2.0 V) and a frequency-compensation coefficient from the calibration ROM.
- Produces a registered, clamped, offset-binary 10-bit DAC code.
- Gain/coefficient changes are deferred to a rising zero crossing so that amplitude steps never glitch mid-cycle.

Parameters:
- SHIFT, 10, arithmetic right shift applied after the /100 scaling.
- UPD_TIMEOUT, 4096, clock cycles a pending coefficient change may wait before it is forced in.
- GAIN_RST, 10, active gain code after reset.
- CAL_RST, 1024, active calibration coefficient after reset.

Ports:
- clk  in  1  stage clock (DAC clock domain).
- rst  in  1  synchronous reset, active-high.
- sample_in  in  10  signed two's-complement sine sample.
- sample_valid  in  1  sample_in is accepted on this cycle.
- gain_in  in  5  unsigned requested gain code.
- cal_in  in  11  unsigned requested calibration coefficient.
- mute  in  1  force mid-scale output.
- dac_code  out  10  offset-binary DAC data, registered.
- dac_valid  out  1  one-cycle strobe, dac_code updated.
- sat  out  1  one-cycle strobe with dac_valid when the clamp engaged.
- upd_done  out  1  one-cycle strobe when new gain/cal became active.

Behaviour:
- Reset (rst=1 at a clk edge):
  - dac_code=512; dac_valid=0; sat=0; upd_done=0.
  - Active gain=GAIN_RST; active cal=CAL_RST.
  - Update FSM in IDLE; prev_neg=0; pipeline valids cleared.
  - Reset mid-operation discards all in-flight samples; no dac_valid appears for them.
- Update FSM states:
  - IDLE: pending=0. If {gain_in,cal_in} differs from the active pair, latch it into shadow registers, clear the timeout counter, go to PEND.
  - PEND: shadow registers track gain_in/cal_in every cycle; timer counts up.
  - Apply from PEND when either condition holds:
    - Crossing: accepted sample with sample_in>=0 and prev_neg=1.
    - Timeout: timer reaches UPD_TIMEOUT-1 (no sample needed).
  - On apply: active pair <= shadow; upd_done=1 for one cycle; go to IDLE.
  - Crossing apply: the crossing sample itself uses the new pair.
  - Timeout apply with a simultaneous accepted sample: that sample uses the new pair.
  - If inputs equal the active pair while in PEND, return to IDLE without upd_done.
  - prev_neg <= sample_in[9] on every accepted sample.
- Pipeline, fixed latency 3 (sample_valid at cycle N -> dac_valid at N+3); full throughput, one sample per cycle.
  - S1: p1 = sample_in * cal (signed 22b, cal zero-extended). Capture the gain in effect with the sample.
  - S2: p2 = p1 * gain (signed 26b, gain zero-extended). Maximum |p2| = 31*2047*512 < 2^25, so no overflow.
  - S3 arithmetic, in order:
    - q = p2 / 100, signed division truncated toward zero.
    - r = q >>> SHIFT, arithmetic shift (floor).
    - v = r + 512.
    - Clamp v to 0..1023; sat=1 if clamped.
  - S3 mute: if mute=1 at S3, dac_code=512 and sat=0.
  - S3 register: dac_code <= result; dac_valid=1.
- dac_code holds its value between strobes.
- sample_valid=0 cycles insert bubbles; bubbles do not disturb prev_neg.

Test Plan:
- Reset, gain_in=10, cal_in=1024; drive sample 511 for one cycle -> dac_code=(10*1024*511/100>>>10)+512=563 exactly 3 cycles later; dac_valid single pulse.
- gain_in=20, cal 1024; samples 511 then -512 -> dac_code 614 then 409 (verifies truncation then floor); sat=0.
- SHIFT=8, gain 31, cal 2047, sample 511 -> dac_code=1023, sat=1. Same with sample -512 -> dac_code 0, sat=1.
- Active gain 10; change gain_in to 20; feed -5, -3, +2, +4 -> the -5 and -3 outputs use gain 10; upd_done on the +2 cycle; +2 and +4 use gain 20.
- Pending change with sample_valid held 0 -> upd_done exactly UPD_TIMEOUT cycles after entry to PEND. Back-to-back samples with mute=1 -> all dac_code=512.
- Assert rst with 2 samples in flight -> no dac_valid afterward; dac_code=512; gain reverts to GAIN_RST.

Source files
------------

// File: rtl/da_gain_pipe.sv
// Amplitude-scaling stage: sine sample x calibration x gain, /100, shift, offset, clamp.
// Gain/cal updates are deferred to a rising zero crossing (or a timeout) to avoid mid-cycle steps.
module da_gain_pipe #(
    parameter int SHIFT       = 10,
    parameter int UPD_TIMEOUT = 4096,
    parameter int GAIN_RST    = 10,
    parameter int CAL_RST     = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  sample_in,
    input  logic        sample_valid,
    input  logic [4:0]  gain_in,
    input  logic [10:0] cal_in,
    input  logic        mute,
    output logic [9:0]  dac_code,
    output logic        dac_valid,
    output logic        sat,
    output logic        upd_done
);

    localparam int TW = (UPD_TIMEOUT > 1) ? $clog2(UPD_TIMEOUT) : 1;

    typedef enum logic {IDLE, PEND} upd_state_t;

    upd_state_t    state;
    logic [4:0]    gain_act, gain_sh, gain_use, g1;
    logic [10:0]   cal_act, cal_sh, cal_use;
    logic [TW-1:0] timer;
    logic          prev_neg;
    logic          req_diff, crossing, timeout, apply;

    logic               v1, v2;
    logic signed [21:0] p1, p1_next;
    logic signed [25:0] p2, p2_next;
    logic signed [25:0] q, r;
    logic signed [26:0] v;
    logic [9:0]         code_next;
    logic               sat_next;

    // A crossing or timeout sample is scaled by the pair that becomes active on the same edge.
    always_comb begin
        req_diff = {gain_in, cal_in} != {gain_act, cal_act};
        crossing = sample_valid && !sample_in[9] && prev_neg;
        timeout  = timer == TW'(UPD_TIMEOUT - 1);
        apply    = (state == PEND) && req_diff && (crossing || timeout);
        gain_use = apply ? gain_sh : gain_act;
        cal_use  = apply ? cal_sh : cal_act;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            gain_act <= 5'(GAIN_RST);
            cal_act  <= 11'(CAL_RST);
            gain_sh  <= '0;
            cal_sh   <= '0;
            timer    <= '0;
            prev_neg <= 1'b0;
            upd_done <= 1'b0;
        end else begin
            upd_done <= 1'b0;
            if (sample_valid) prev_neg <= sample_in[9];
            case (state)
                IDLE: begin
                    if (req_diff) begin
                        gain_sh <= gain_in;
                        cal_sh  <= cal_in;
                        timer   <= '0;
                        state   <= PEND;
                    end
                end
                PEND: begin
                    if (!req_diff) begin
                        state <= IDLE;
                    end else if (apply) begin
                        gain_act <= gain_sh;
                        cal_act  <= cal_sh;
                        upd_done <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        gain_sh <= gain_in;
                        cal_sh  <= cal_in;
                        timer   <= timer + TW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        // NOTE: every output of this block is assigned on all paths, so no latch is inferred.
        p1_next   = 22'($signed(sample_in)) * 22'($signed({1'b0, cal_use}));
        p2_next   = 26'(p1) * 26'($signed({1'b0, g1}));
        q         = p2 / 26'sd100;
        r         = q >>> SHIFT;
        v         = 27'(r) + 27'sd512;
        code_next = v[9:0];
        sat_next  = 1'b0;
        if (v < 27'sd0) begin
            code_next = 10'd0;
            sat_next  = 1'b1;
        end else if (v > 27'sd1023) begin
            code_next = 10'd1023;
            sat_next  = 1'b1;
        end
        if (mute) begin
            code_next = 10'd512;
            sat_next  = 1'b0;
        end
    end

    // NOTE: datapath registers carry no reset; the valid bits alone decide whether they are used.
    always_ff @(posedge clk) begin
        if (sample_valid) begin
            p1 <= p1_next;
            g1 <= gain_use;
        end
        if (v1) p2 <= p2_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            dac_valid <= 1'b0;
            sat       <= 1'b0;
            dac_code  <= 10'd512;
        end else begin
            v1        <= sample_valid;
            v2        <= v1;
            dac_valid <= v2;
            sat       <= v2 && sat_next;
            if (v2) dac_code <= code_next;
        end
    end

endmodule

// File: tb/tb_da_gain_pipe.sv
// Scoreboard bench for da_gain_pipe: two instances (SHIFT 10 and 8) share stimulus;
// a reference model pushes expected codes, a monitor pops them when dac_valid strobes.
module tb_da_gain_pipe;

    localparam int TMO      = 64;
    localparam int GAIN_RST = 10;
    localparam int CAL_RST  = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  sample_in = '0;
    logic        sample_valid = 1'b0;
    logic [4:0]  gain_in = 5'd10;
    logic [10:0] cal_in = 11'd1024;
    logic        mute = 1'b0;
    logic [9:0]  code_a, code_b;
    logic        valid_a, valid_b, sat_a, sat_b, upd_a, upd_b;

    always #5 clk = ~clk;

    da_gain_pipe #(.SHIFT(10), .UPD_TIMEOUT(TMO), .GAIN_RST(GAIN_RST), .CAL_RST(CAL_RST)) u_dut_a (
        .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
        .gain_in(gain_in), .cal_in(cal_in), .mute(mute),
        .dac_code(code_a), .dac_valid(valid_a), .sat(sat_a), .upd_done(upd_a));

    da_gain_pipe #(.SHIFT(8), .UPD_TIMEOUT(TMO), .GAIN_RST(GAIN_RST), .CAL_RST(CAL_RST)) u_dut_b (
        .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
        .gain_in(gain_in), .cal_in(cal_in), .mute(mute),
        .dac_code(code_b), .dac_valid(valid_b), .sat(sat_b), .upd_done(upd_b));

    typedef struct {
        int code_a;
        bit sat_a;
        int code_b;
        bit sat_b;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    int act_g = GAIN_RST, act_c = CAL_RST, sh_g = 0, sh_c = 0, wait_cnt = 0;
    bit pending = 0, prev_neg = 0, exp_upd = 0;

    task automatic check(input string name, input int actual, input int expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Reference arithmetic in plain integers: truncating /100, then floor division by 2^sh.
    function automatic void ref_out(input int s, input int g, input int c, input int sh,
                                    input bit m, output int code, output bit sat_o);
        longint p, q, r, v, d;
        p = longint'(s) * c * g;
        q = p / 100;
        d = longint'(1) << sh;
        r = q / d;
        if (q < 0 && (q % d) != 0) r = r - 1;
        v = r + 512;
        sat_o = 1'b0;
        if (v < 0) begin
            v = 0;
            sat_o = 1'b1;
        end else if (v > 1023) begin
            v = 1023;
            sat_o = 1'b1;
        end
        code = int'(v);
        if (m) begin
            code  = 512;
            sat_o = 1'b0;
        end
    endfunction

    // Predicts what the upcoming clock edge does, from the inputs just driven.
    task automatic model_step();
        int   s, gu, cu;
        bit   diff;
        exp_t e;
        exp_upd = 1'b0;
        if (rst) begin
            act_g = GAIN_RST; act_c = CAL_RST;
            pending = 0; prev_neg = 0;
            exp_q.delete();
            return;
        end
        s    = int'($signed(sample_in));
        gu   = act_g;
        cu   = act_c;
        diff = (int'(gain_in) != act_g) || (int'(cal_in) != act_c);
        if (!pending) begin
            if (diff) begin
                pending = 1; sh_g = int'(gain_in); sh_c = int'(cal_in); wait_cnt = 0;
            end
        end else if (!diff) begin
            pending = 0;
        end else if ((sample_valid && s >= 0 && prev_neg) || wait_cnt == TMO - 1) begin
            act_g = sh_g; act_c = sh_c; gu = sh_g; cu = sh_c;
            pending = 0; exp_upd = 1'b1;
        end else begin
            sh_g = int'(gain_in); sh_c = int'(cal_in); wait_cnt++;
        end
        if (sample_valid) begin
            ref_out(s, gu, cu, 10, mute, e.code_a, e.sat_a);
            ref_out(s, gu, cu, 8,  mute, e.code_b, e.sat_b);
            exp_q.push_back(e);
            prev_neg = (s < 0);
        end
    endtask

    task automatic tick(input bit r, input bit v, input int s, input int g, input int c, input bit m);
        @(negedge clk);
        rst = r; sample_valid = v; sample_in = 10'(s);
        gain_in = 5'(g); cal_in = 11'(c); mute = m;
        model_step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0, int'(gain_in), int'(cal_in), mute);
    endtask

    // Monitor: decoupled from stimulus, compares whenever the DUTs strobe.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            check("upd_done_a", upd_a, exp_upd);
            check("upd_done_b", upd_b, exp_upd);
            if (valid_a || valid_b) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_valid: got dac_valid a=%0b b=%0b, expected none (t=%0t)",
                             valid_a, valid_b, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("valid_a", valid_a, 1);
                    check("valid_b", valid_b, 1);
                    check("code_a", code_a, e.code_a);
                    check("sat_a", sat_a, e.sat_a);
                    check("code_b", code_b, e.code_b);
                    check("sat_b", sat_b, e.sat_b);
                end
            end
        end
    end

    initial begin
        int n, s, g, c, tri_v, tri_d, mode;
        tick(1, 0, 0, 10, 1024, 0);
        tick(1, 0, 0, 10, 1024, 0);
        @(posedge clk); #1;
        check("rst_code", code_a, 512);
        check("rst_valid", valid_a, 0);
        check("rst_sat", sat_a, 0);

        // Basic scaling at reset gain/cal, single-pulse valid.
        tick(0, 1, 511, 10, 1024, 0);
        idle(2);
        @(posedge clk); #1;
        check("basic_valid", valid_a, 1);
        check("basic_code", code_a, 563);
        idle(1);
        @(posedge clk); #1;
        check("basic_pulse", valid_a, 0);
        idle(2);

        // Gain 20 via crossing; truncation then floor.
        tick(0, 1, -1, 20, 1024, 0);
        tick(0, 1, 511, 20, 1024, 0);
        tick(0, 1, -512, 20, 1024, 0);
        idle(1);
        @(posedge clk); #1;
        check("g20_pos_code", code_a, 614);
        check("g20_pos_sat", sat_a, 0);
        idle(1);
        @(posedge clk); #1;
        check("g20_neg_code", code_a, 409);
        check("g20_neg_sat", sat_a, 0);
        idle(2);

        // Clamp on the SHIFT=8 instance.
        tick(0, 1, -512, 31, 2047, 0);
        tick(0, 1, 511, 31, 2047, 0);
        tick(0, 1, -512, 31, 2047, 0);
        idle(1);
        @(posedge clk); #1;
        check("clamp_hi_code", code_b, 1023);
        check("clamp_hi_sat", sat_b, 1);
        idle(1);
        @(posedge clk); #1;
        check("clamp_lo_code", code_b, 0);
        check("clamp_lo_sat", sat_b, 1);
        idle(2);

        // Back to gain 10, then a crossing-deferred change to 20.
        tick(0, 0, 0, 10, 1024, 0);
        tick(0, 1, 100, 10, 1024, 0);
        idle(3);
        tick(0, 1, -5, 20, 1024, 0);
        tick(0, 1, -3, 20, 1024, 0);
        tick(0, 1, 2, 20, 1024, 0);
        @(posedge clk); #1;
        check("cross_upd_done", upd_a, 1);
        tick(0, 1, 4, 20, 1024, 0);
        idle(4);

        // Timeout with no samples.
        tick(0, 0, 0, 15, 1024, 0);
        n = 0;
        for (int i = 0; i < TMO + 10; i++) begin
            tick(0, 0, 0, 15, 1024, 0);
            @(posedge clk); #1;
            n++;
            if (upd_a) break;
        end
        check("timeout_latency", n, TMO);
        idle(3);

        // Mute: back-to-back samples.
        tick(0, 0, 0, 15, 1024, 1);
        for (int i = 0; i < 8; i++) tick(0, 1, (i % 2) ? 511 : -512, 15, 1024, 1);
        idle(3);
        @(posedge clk); #1;
        check("mute_code", code_a, 512);
        tick(0, 0, 0, 15, 1024, 0);
        idle(3);

        // Reset with two samples in flight.
        tick(0, 1, 511, 15, 1024, 0);
        tick(0, 1, -300, 15, 1024, 0);
        tick(1, 0, 0, 10, 1024, 0);
        tick(0, 0, 0, 10, 1024, 0);
        @(posedge clk); #1;
        check("midrst_code", code_a, 512);
        check("midrst_valid", valid_a, 0);
        idle(3);
        tick(0, 1, 511, 10, 1024, 0);
        idle(2);
        @(posedge clk); #1;
        check("midrst_gain_revert", code_a, 563);
        idle(3);

        // Randomized traffic in four regimes.
        g = 10; c = 1024; tri_v = 0; tri_d = 37;
        for (int i = 0; i < 3000; i++) begin
            mode = (i / 250) % 4;
            if ($urandom_range(0, 29) == 0) begin
                g = $urandom_range(0, 31);
                c = $urandom_range(0, 2047);
            end
            tri_v = tri_v + tri_d;
            if (tri_v > 511 || tri_v < -512) begin
                tri_d = -tri_d;
                tri_v = tri_v + 2 * tri_d;
            end
            case (mode)
                0: s = $urandom_range(0, 1023) - 512;
                1: s = $urandom_range(0, 1023) - 512;
                2: s = $urandom_range(0, 511);
                default: s = tri_v;
            endcase
            if (mode == 1) tick(0, $urandom_range(0, 4) == 0, s, g, c, 0);
            else           tick(0, $urandom_range(0, 3) != 0, s, g, c, 0);
        end
        idle(6);
        check("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
